// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: reset/bubble constants and the IF/ID payload.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            misalign;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: sync active-low reset, flush to a bubble, load on enable.
module if_id_reg
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // Flush keeps the pc fields so decode still sees the last address on a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q.valid    <= 1'b0;
            q.instr    <= NOP_WORD;
            q.pc       <= '0;
            q.pc_plus4 <= '0;
            q.misalign <= 1'b0;
        end else if (flush) begin
            q.valid    <= 1'b0;
            q.instr    <= NOP_WORD;
            q.misalign <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, next-PC selection, misaligned-target flag,
// fetch counter and the IF/ID register feeding decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = rv32i_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o,
    output logic        id_misalign_o,
    output logic [31:0] fetch_cnt_o
);

    localparam int unsigned XLEN = rv32i_pkg::XLEN;

    logic [XLEN-1:0]   pc_q;
    logic              misalign_pend_q;
    logic [XLEN-1:0]   fetch_cnt_q;
    logic [XLEN-1:0]   pc_plus4_c;
    logic              advance_c;
    rv32i_pkg::if_id_t if_id_d;
    rv32i_pkg::if_id_t if_id_q;

    assign pc_plus4_c = pc_q + XLEN'(4);
    assign advance_c  = !stall_i && !redirect_i;

    // Entry captured on an advance; the misalign flag tags the first fetch after a redirect.
    always_comb begin
        if_id_d          = '0;
        if_id_d.valid    = 1'b1;
        if_id_d.instr    = imem_instr_i;
        if_id_d.pc       = pc_q;
        if_id_d.pc_plus4 = pc_plus4_c;
        if_id_d.misalign = misalign_pend_q;
    end

    // Redirect beats stall: a taken branch in EX must never be held back by a load-use bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC;
            misalign_pend_q <= 1'b0;
            fetch_cnt_q     <= '0;
        end else if (redirect_i) begin
            pc_q            <= {redirect_pc_i[31:2], 2'b00};
            misalign_pend_q <= |redirect_pc_i[1:0];
        end else if (!stall_i) begin
            pc_q            <= pc_plus4_c;
            misalign_pend_q <= 1'b0;
            fetch_cnt_q     <= fetch_cnt_q + XLEN'(1);
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance_c),
        .flush (redirect_i),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign imem_addr_o   = pc_q;
    assign id_valid_o    = if_id_q.valid;
    assign id_instr_o    = if_id_q.instr;
    assign id_pc_o       = if_id_q.pc;
    assign id_pc_plus4_o = if_id_q.pc_plus4;
    assign id_misalign_o = if_id_q.misalign;
    assign fetch_cnt_o   = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect/reset traffic
// compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_misalign;
    logic [31:0] fetch_cnt;

    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic        w_valid;
    logic [31:0] w_id_instr;
    logic [31:0] w_id_pc;
    logic [31:0] w_id_pc_plus4;
    logic        w_misalign;
    logic [31:0] w_cnt;

    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    // Reference model state for the default-RESET_PC instance.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_ip4;
    logic        m_mis;
    logic        m_pend;
    logic [31:0] m_cnt;

    assign imem_instr = mem[imem_addr[9:2]];
    assign w_instr    = mem[w_addr[9:2]];

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr),
        .imem_instr_i  (imem_instr),
        .id_valid_o    (id_valid),
        .id_instr_o    (id_instr),
        .id_pc_o       (id_pc),
        .id_pc_plus4_o (id_pc_plus4),
        .id_misalign_o (id_misalign),
        .fetch_cnt_o   (fetch_cnt)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (w_addr),
        .imem_instr_i  (w_instr),
        .id_valid_o    (w_valid),
        .id_instr_o    (w_id_instr),
        .id_pc_o       (w_id_pc),
        .id_pc_plus4_o (w_id_pc_plus4),
        .id_misalign_o (w_misalign),
        .fetch_cnt_o   (w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, step the model across the edge, sample 1 time unit later.
    task automatic cycle(input logic r, input logic s, input logic d, input logic [31:0] t);
        rst_n = r; stall_i = s; redirect_i = d; redirect_pc_i = t;
        @(posedge clk);
        if (!r) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h13; m_ipc = 32'h0;
            m_ip4 = 32'h0; m_mis = 1'b0; m_pend = 1'b0; m_cnt = 32'h0;
        end else if (d) begin
            m_pc = t & 32'hFFFF_FFFC; m_valid = 1'b0; m_instr = 32'h13;
            m_mis = 1'b0; m_pend = (t % 4) != 0;
        end else if (!s) begin
            m_valid = 1'b1; m_instr = mem[m_pc[9:2]]; m_ipc = m_pc;
            m_ip4 = m_pc + 32'd4; m_mis = m_pend; m_pend = 1'b0;
            m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h55);
        checks++;
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
        checks++;
        if (id_valid !== 1'b0 || id_misalign !== 1'b0) begin
            errors++; $display("FAIL reset_flags got valid=%b mis=%b exp 0 0", id_valid, id_misalign);
        end
        checks++;
        if (id_instr !== 32'h13) begin errors++; $display("FAIL reset_instr got=%h exp=%h", id_instr, 32'h13); end
        checks++;
        if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0 || fetch_cnt !== 32'h0) begin
            errors++; $display("FAIL reset_pc_cnt got pc=%h pc4=%h cnt=%h exp 0", id_pc, id_pc_plus4, fetch_cnt);
        end
    endtask

    task automatic test_advance();
        logic [31:0] exp_addr;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_addr = 32'(i * 4);
            checks++;
            if (imem_addr !== exp_addr) begin errors++; $display("FAIL adv_addr%0d got=%h exp=%h", i, imem_addr, exp_addr); end
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            if (i == 0) begin
                checks++;
                if (id_instr !== 32'h0050_0093 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4 || id_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL adv_first got instr=%h pc=%h pc4=%h v=%b exp 00500093 0 4 1",
                             id_instr, id_pc, id_pc_plus4, id_valid);
                end
            end
        end
        checks++;
        if (fetch_cnt !== 32'd4) begin errors++; $display("FAIL adv_cnt got=%0d exp=4", fetch_cnt); end
        checks++;
        if (id_instr !== mem[3] || id_pc !== 32'hC) begin
            errors++; $display("FAIL adv_last got instr=%h pc=%h exp %h c", id_instr, id_pc, mem[3]);
        end
    endtask

    task automatic test_stall();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if (imem_addr !== 32'h8 || id_pc !== 32'h4 || id_instr !== mem[1] || fetch_cnt !== 32'd2 || id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d got addr=%h pc=%h instr=%h cnt=%0d v=%b exp 8 4 %h 2 1",
                         i, imem_addr, id_pc, id_instr, fetch_cnt, id_valid, mem[1]);
            end
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'hC || id_pc !== 32'h8 || fetch_cnt !== 32'd3) begin
            errors++; $display("FAIL stall_resume got addr=%h pc=%h cnt=%0d exp c 8 3", imem_addr, id_pc, fetch_cnt);
        end
    endtask

    task automatic test_redirect();
        cycle(1'b1, 1'b1, 1'b1, 32'h40);
        checks++;
        if (id_valid !== 1'b0 || id_instr !== 32'h13 || imem_addr !== 32'h40) begin
            errors++; $display("FAIL redir_bubble got v=%b instr=%h addr=%h exp 0 13 40", id_valid, id_instr, imem_addr);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== mem[16]) begin
            errors++; $display("FAIL redir_target got v=%b pc=%h instr=%h exp 1 40 %h", id_valid, id_pc, id_instr, mem[16]);
        end
    endtask

    task automatic test_misalign();
        cycle(1'b1, 1'b0, 1'b1, 32'h42);
        checks++;
        if (imem_addr !== 32'h40 || id_misalign !== 1'b0) begin
            errors++; $display("FAIL mis_addr got addr=%h mis=%b exp 40 0", imem_addr, id_misalign);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (id_misalign !== 1'b1 || id_pc !== 32'h40) begin
            errors++; $display("FAIL mis_tag got mis=%b pc=%h exp 1 40", id_misalign, id_pc);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (id_misalign !== 1'b0 || id_pc !== 32'h44) begin
            errors++; $display("FAIL mis_clear got mis=%b pc=%h exp 0 44", id_misalign, id_pc);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 1'b0, 1'b1, 32'h80);
        cycle(1'b1, 1'b0, 1'b1, 32'h107);
        checks++;
        if (imem_addr !== 32'h104 || id_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_addr got addr=%h v=%b exp 104 0", imem_addr, id_valid);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (id_pc !== 32'h104 || id_valid !== 1'b1 || id_misalign !== 1'b1) begin
            errors++; $display("FAIL b2b_target got pc=%h v=%b mis=%b exp 104 1 1", id_pc, id_valid, id_misalign);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start got=%h exp=fffffffc", w_addr); end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (w_addr !== 32'h0 || w_id_pc !== 32'hFFFF_FFFC || w_id_pc_plus4 !== 32'h0 || w_id_instr !== mem[255]) begin
            errors++;
            $display("FAIL wrap_entry got addr=%h pc=%h pc4=%h instr=%h exp 0 fffffffc 0 %h",
                     w_addr, w_id_pc, w_id_pc_plus4, w_id_instr, mem[255]);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (w_addr !== 32'h4 || w_id_pc !== 32'h0 || w_cnt !== 32'd2) begin
            errors++; $display("FAIL wrap_next got addr=%h pc=%h cnt=%0d exp 4 0 2", w_addr, w_id_pc, w_cnt);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h46);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'h0 || id_valid !== 1'b0 || id_instr !== 32'h13 || id_pc !== 32'h0 ||
            id_pc_plus4 !== 32'h0 || id_misalign !== 1'b0 || fetch_cnt !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got addr=%h v=%b instr=%h pc=%h pc4=%h mis=%b cnt=%h exp reset values",
                     imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, id_misalign, fetch_cnt);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (id_misalign !== 1'b0 || id_pc !== 32'h0 || id_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pend got mis=%b pc=%h v=%b exp 0 0 1", id_misalign, id_pc, id_valid);
        end
    endtask

    task automatic test_random();
        logic [161:0] got;
        logic [161:0] exp;
        logic         r, s, d;
        logic [31:0]  t;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) != 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 5) == 0);
            t = $urandom_range(0, 1023);
            cycle(r, s, d, t);
            got = {imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, id_misalign, fetch_cnt};
            exp = {m_pc, m_valid, m_instr, m_ipc, m_ip4, m_mis, m_cnt};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_cycle%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        test_reset();
        test_advance();
        test_stall();
        test_redirect();
        test_misalign();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch (IF) stage of the five-stage RV32I pipeline. Owns the program counter and drives the combinational, word-addressed instruction memory read port. Registers the returned instruction into the IF/ID pipeline register consumed by decode. Handles hazard-unit stalls, EX-stage branch/jump redirects with flush, misaligned-target detection and a fetch counter.

## Interface
- `RESET_PC`, `32'h0000_0000`: PC value loaded on reset.
- `NOP_INSTR`, `32'h0000_0013`: bubble instruction (`addi x0,x0,0`) placed in IF/ID on reset or flush.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `stall_i` in 1: hazard-unit stall (load-use); hold PC and IF/ID.
- `redirect_i` in 1: EX resolved taken branch / JAL / JALR.
- `redirect_pc_i` in 32: redirect target byte address.
- `imem_addr_o` out 32: byte address to instruction memory; equals `pc_q` combinationally.
- `imem_instr_i` in 32: instruction returned combinationally for `imem_addr_o`.
- `id_valid_o` out 1: IF/ID holds a real instruction.
- `id_instr_o` out 32: IF/ID instruction.
- `id_pc_o` out 32: PC of `id_instr_o`.
- `id_pc_plus4_o` out 32: `id_pc_o + 4` (link value for JAL/JALR).
- `id_misalign_o` out 1: IF/ID entry results from a redirect whose target had `[1:0] != 0`.
- `fetch_cnt_o` out 32: number of instructions that entered IF/ID with `id_valid_o=1`.

## Operation
- Registers: `pc_q`, IF/ID (`valid`, `instr`, `pc`, `pc_plus4`, `misalign`), `misalign_pend_q`, `fetch_cnt_q`.
- Priority per edge: reset > redirect > stall > advance.
- Reset (`rst_n=0` at edge): `pc_q=RESET_PC`, `id_valid_o=0`, `id_instr_o=NOP_INSTR`, `id_pc_o=0`, `id_pc_plus4_o=0`, `id_misalign_o=0`, `misalign_pend_q=0`, `fetch_cnt_o=0`. Reset mid-operation discards any pending redirect or stall.
- Advance (`stall_i=0`, `redirect_i=0`): `pc_q <= pc_q+4`. IF/ID loads `valid=1`, `instr=imem_instr_i`, `pc=pc_q`, `pc_plus4=pc_q+4`, `misalign=misalign_pend_q`. `misalign_pend_q <= 0`. `fetch_cnt_q` increments.
- Stall (`stall_i=1`, `redirect_i=0`): `pc_q`, IF/ID, `misalign_pend_q` and the counter hold.
- Redirect (`redirect_i=1`, stall ignored): `pc_q <= {redirect_pc_i[31:2],2'b00}`. IF/ID flushes to `valid=0`, `instr=NOP_INSTR`, `misalign=0`; pc fields hold. `misalign_pend_q <= |redirect_pc_i[1:0]`. Counter holds. This discards the wrong-path instruction fetched in the redirect cycle.
- Arithmetic: all PC math is 32-bit modulo 2^32; `32'hFFFF_FFFC + 4` wraps to `0`. The counter wraps from `32'hFFFF_FFFF` to `0`.
- No state machine beyond the flags above. Decode must treat `id_valid_o=0` as a bubble.

## Timing
- `imem_addr_o` is combinational from `pc_q`. Instruction memory is combinational, so fetch completes in the same cycle and the IF-to-ID latency is 1 cycle.
- First fetch: the cycle after `rst_n` rises, `imem_addr_o=RESET_PC`. At the end of that cycle, IF/ID holds the instruction at `RESET_PC` with `valid=1`.
- Redirect penalty: if `redirect_i` is asserted in cycle N, IF/ID is a bubble in cycle N+1 and holds the target instruction from cycle N+2. One lost fetch slot in IF, plus the ID slot flushed by EX.
- A stall asserted for k consecutive cycles freezes all outputs for exactly k cycles. The advance resumes on the first cycle with `stall_i=0`.
- Back-to-back redirects: each one takes effect independently, and the last one wins.

## Structure
- Shared package `rv32i_pkg`: `RESET_PC_DEFAULT`, `NOP_INSTR` (`32'h0000_0013`), and the packed struct `if_id_t` {`valid`, `instr`, `pc`, `pc_plus4`, `misalign`}. Decode reuses `if_id_t`.
- One sub-module: `if_id_reg`, which holds the `if_id_t` register with `en` (advance), `flush` and synchronous active-low reset. `fetch_stage` contains the PC, next-PC mux, misalign flag and counter.

## Test plan
- Reset then run 4 cycles with memory `[0]=0x00500093, [1]=0x00A00113, …` → `imem_addr_o` 0,4,8,12. `id_instr_o=0x00500093`, `id_pc_o=0`, `id_pc_plus4_o=4` after the first advance. `fetch_cnt_o=4`.
- `stall_i=1` for 3 cycles at `pc_q=8` → `imem_addr_o` stays 8 and IF/ID holds the pc=4 entry for 3 cycles. Resume → pc 12, counter unchanged during the stall.
- `redirect_i=1`, `redirect_pc_i=0x40`, with `stall_i=1` in the same cycle → next cycle `id_valid_o=0`, `id_instr_o=0x13`, `imem_addr_o=0x40`. The following cycle `id_pc_o=0x40`, `valid=1`.
- `redirect_pc_i=0x42` → `imem_addr_o=0x40`. The entry for 0x40 has `id_misalign_o=1` and the next entry has `id_misalign_o=0`.
- `RESET_PC=0xFFFF_FFFC`, advance 2 cycles → `imem_addr_o` goes 0xFFFF_FFFC then 0x0. The entry for 0xFFFF_FFFC has `id_pc_plus4_o=0`.
- `rst_n=0` for one cycle during a stall with a pending misalign → all outputs return to reset values and `misalign_pend_q=0`.
